// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects the next control-store address from the
// incrementer, branch input, loop counter or a return stack.
module micro_sequencer #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [2:0]    instr,
  input  logic          cond,
  input  logic [AW-1:0] d,
  input  logic          hold,
  output logic [AW-1:0] y,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    I_JZ   = 3'd0,
    I_CJS  = 3'd1,
    I_JMAP = 3'd2,
    I_CJP  = 3'd3,
    I_PUSH = 3'd4,
    I_RFCT = 3'd5,
    I_CRTN = 3'd6,
    I_CONT = 3'd7
  } instr_e;

  logic [AW-1:0]  upc_q, upc_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic [AW-1:0]  stack_d [DEPTH];

  logic [AW-1:0]  y_sel;
  logic [AW-1:0]  tos;
  logic           push;
  logic           pop;
  logic           clear;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);
  assign err   = err_q;
  // Reset state alone would not zero y for branch-to-d instructions.
  assign y     = reset_n ? y_sel : '0;

  // Top of stack; zero when the stack is empty.
  always_comb begin
    tos = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sp_q == SPW'(i + 1)) tos = stack_q[i];
    end
  end

  // Instruction decode: address select and stack/counter effects.
  always_comb begin
    y_sel = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    cnt_d = cnt_q;
    case (instr_e'(instr))
      I_JZ:   begin y_sel = '0; clear = 1'b1; end
      I_CJS:  if (cond) begin y_sel = d; push = 1'b1; end
      I_JMAP: y_sel = d;
      I_CJP:  if (cond) y_sel = d;
      I_PUSH: begin
        push = 1'b1;
        if (cond) cnt_d = d;
      end
      I_RFCT: begin
        if (cnt_q != '0) begin
          y_sel = tos;
          cnt_d = cnt_q - AW'(1);
        end else begin
          pop = 1'b1;
        end
      end
      I_CRTN: if (cond) begin y_sel = tos; pop = 1'b1; end
      I_CONT: y_sel = upc_q;
      default: y_sel = upc_q;
    endcase
  end

  // Next-state for upc, stack pointer, stack contents and error flag.
  always_comb begin
    upc_d   = upc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (!hold) begin
      upc_d = y_sel + AW'(1);
      if (clear) begin
        sp_d  = '0;
        err_d = 1'b0;
      end else if (push) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (sp_q == SPW'(i)) stack_d[i] = upc_q;
          end
          sp_d = sp_q + SPW'(1);
        end
      end else if (pop) begin
        if (empty) err_d = 1'b1;
        else       sp_d  = sp_q - SPW'(1);
      end
    end
  end

  // State registers; hold also freezes the loop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc_q <= '0;
      cnt_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
    end else begin
      upc_q   <= upc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      stack_q <= stack_d;
      if (!hold) cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer (AW=12, DEPTH=5).
module tb_micro_sequencer;

  localparam logic [2:0] JZ = 3'd0, CJS = 3'd1, JMAP = 3'd2, CJP = 3'd3,
                         PUSH = 3'd4, RFCT = 3'd5, CRTN = 3'd6, CONT = 3'd7;

  typedef struct {
    logic [2:0]  instr;
    logic        cond;
    logic [11:0] d;
    logic        hold;
    logic [11:0] y;
    logic [2:0]  fer;   // {full, empty, err} before this cycle's edge
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  instr;
  logic        cond;
  logic [11:0] d;
  logic        hold;
  logic [11:0] y;
  logic        full, empty, err;

  int total = 0;
  int bad   = 0;
  vec_t tv[$];

  micro_sequencer #(.AW(12), .DEPTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .cond(cond), .d(d),
    .hold(hold), .y(y), .full(full), .empty(empty), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] i, input logic c, input logic [11:0] dv,
                     input logic h, input logic [11:0] ye, input logic [2:0] f);
    vec_t v;
    v.instr = i; v.cond = c; v.d = dv; v.hold = h; v.y = ye; v.fer = f;
    tv.push_back(v);
  endtask

  initial begin
    // Expected y from the instruction rules; flags reflect state before the edge.
    add(CONT, 0, 12'h000, 0, 12'h000, 3'b010);
    add(CONT, 0, 12'h000, 0, 12'h001, 3'b010);
    add(CONT, 0, 12'h000, 0, 12'h002, 3'b010);
    add(CJP,  0, 12'h100, 0, 12'h003, 3'b010);
    add(CJP,  1, 12'h00F, 0, 12'h00F, 3'b010);
    add(CJS,  1, 12'h200, 0, 12'h200, 3'b010);
    add(CRTN, 1, 12'h000, 0, 12'h010, 3'b000);
    add(CONT, 0, 12'h000, 0, 12'h011, 3'b010);
    add(JMAP, 0, 12'h01F, 0, 12'h01F, 3'b010);
    add(PUSH, 1, 12'h002, 0, 12'h020, 3'b010);
    add(RFCT, 0, 12'h000, 0, 12'h020, 3'b000);
    add(RFCT, 0, 12'h000, 0, 12'h020, 3'b000);
    add(RFCT, 0, 12'h000, 0, 12'h021, 3'b000);
    add(CONT, 0, 12'h000, 0, 12'h022, 3'b010);
    add(CJS,  0, 12'h300, 0, 12'h023, 3'b010);
    add(CRTN, 0, 12'h000, 0, 12'h024, 3'b010);
    add(PUSH, 0, 12'h777, 0, 12'h025, 3'b010);
    add(RFCT, 0, 12'h000, 0, 12'h026, 3'b000);
    add(CRTN, 1, 12'h000, 0, 12'h000, 3'b010);
    add(CONT, 0, 12'h000, 0, 12'h001, 3'b011);
    add(CJS,  1, 12'h0AA, 1, 12'h0AA, 3'b011);
    add(CONT, 0, 12'h000, 0, 12'h002, 3'b011);
    add(JZ,   0, 12'h000, 0, 12'h000, 3'b011);
    add(CONT, 0, 12'h000, 0, 12'h001, 3'b010);
    add(CJS,  1, 12'h040, 0, 12'h040, 3'b010);
    add(CJS,  1, 12'h040, 0, 12'h040, 3'b000);
    add(CJS,  1, 12'h040, 0, 12'h040, 3'b000);
    add(CJS,  1, 12'h040, 0, 12'h040, 3'b000);
    add(CJS,  1, 12'h040, 0, 12'h040, 3'b000);
    add(CJS,  1, 12'h040, 0, 12'h040, 3'b100);
    add(CONT, 0, 12'h000, 0, 12'h041, 3'b101);
    add(JZ,   0, 12'h000, 1, 12'h000, 3'b101);
    add(JZ,   0, 12'h000, 0, 12'h000, 3'b101);
    add(CONT, 0, 12'h000, 0, 12'h001, 3'b010);
    add(RFCT, 0, 12'h000, 0, 12'h002, 3'b010);
    add(CONT, 0, 12'h000, 0, 12'h003, 3'b011);
    add(CJP,  1, 12'hFFE, 0, 12'hFFE, 3'b011);
    add(CONT, 0, 12'h000, 0, 12'hFFF, 3'b011);
    add(CONT, 0, 12'h000, 0, 12'h000, 3'b011);
    add(JZ,   0, 12'h000, 0, 12'h000, 3'b011);
    add(CRTN, 1, 12'h000, 0, 12'h000, 3'b010);

    reset_n = 1'b0; instr = CONT; cond = 1'b0; d = '0; hold = 1'b0;
    #1;
    chk("reset_y", y, 12'h000);
    chk("reset_flags", {9'd0, full, empty, err}, 12'h002);

    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < tv.size(); k++) begin
      instr = tv[k].instr; cond = tv[k].cond; d = tv[k].d; hold = tv[k].hold;
      #1;
      chk($sformatf("vec%0d_y", k), y, tv[k].y);
      chk($sformatf("vec%0d_flags", k), {9'd0, full, empty, err}, {9'd0, tv[k].fer});
      @(negedge clock);
    end

    // Final CRTN on empty stack left err set; async reset clears it between edges.
    instr = CJS; cond = 1'b1; d = 12'h155; hold = 1'b0;
    #1;
    chk("pre_rst_y", y, 12'h155);
    chk("pre_rst_err", {11'd0, err}, 12'h001);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_y", y, 12'h000);
    chk("async_rst_flags", {9'd0, full, empty, err}, 12'h002);

    // Reset outranks hold across a clock edge.
    hold = 1'b1;
    @(posedge clock); #1;
    chk("rst_hold_y", y, 12'h000);
    chk("rst_hold_flags", {9'd0, full, empty, err}, 12'h002);

    @(negedge clock);
    reset_n = 1'b1; hold = 1'b0; instr = CONT; cond = 1'b0;
    #1;
    chk("release_y0", y, 12'h000);
    @(negedge clock); #1;
    chk("release_y1", y, 12'h001);
    @(negedge clock); #1;
    chk("release_y2", y, 12'h002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
